// File: rtl/crash_course_cpu_gpio.sv
// crash_course_cpu_gpio: PORT_COUNT x DATA_WIDTH GPIO (IN/OUT/DIR/PEND per port at addr {port,sel}); io_in synchronized, rising edges latch W1C PEND, irq = registered OR of PEND; clk_en&&system_enabled gate all non-reset updates
module crash_course_cpu_gpio #(
  parameter int DATA_WIDTH = 8,
  parameter int PORT_COUNT = 4,
  parameter int SYNC_STAGES = 2,
  localparam int ADDR_WIDTH = $clog2(PORT_COUNT) + 2
) (
  input  logic                             clk,
  input  logic                             sync_rst_n,
  input  logic                             clk_en,
  input  logic                             system_enabled,
  input  logic [PORT_COUNT*DATA_WIDTH-1:0] io_in,
  output logic [PORT_COUNT*DATA_WIDTH-1:0] io_out,
  output logic [PORT_COUNT*DATA_WIDTH-1:0] io_oe,
  input  logic [ADDR_WIDTH-1:0]            reg_addr,
  output logic [DATA_WIDTH-1:0]            reg_read_data,
  input  logic [DATA_WIDTH-1:0]            reg_write_data,
  input  logic                             reg_write_enable,
  output logic                             irq
);
  localparam int N = PORT_COUNT * DATA_WIDTH;
  logic en;
  logic [31:0] pi;
  logic [1:0] sel;
  logic [N-1:0] sync_q [SYNC_STAGES];
  logic [N-1:0] in_q, prev_q, pend_q, out_n, dir_n, clr;
  assign en = clk_en & system_enabled;
  assign pi = 32'(reg_addr >> 2);
  assign sel = reg_addr[1:0];
  assign in_q = sync_q[SYNC_STAGES-1];
  always_comb begin
    out_n = io_out;
    dir_n = io_oe;
    clr = '0;
    if (reg_write_enable && pi < PORT_COUNT) begin
      if (sel == 2'd1) out_n[pi*DATA_WIDTH +: DATA_WIDTH] = reg_write_data;
      if (sel == 2'd2) dir_n[pi*DATA_WIDTH +: DATA_WIDTH] = reg_write_data;
      if (sel == 2'd3) clr[pi*DATA_WIDTH +: DATA_WIDTH] = reg_write_data;
    end
  end
  always_comb begin
    reg_read_data = '0;
    if (pi < PORT_COUNT)
      reg_read_data = sel == 2'd0 ? in_q[pi*DATA_WIDTH +: DATA_WIDTH] :
                      sel == 2'd1 ? io_out[pi*DATA_WIDTH +: DATA_WIDTH] :
                      sel == 2'd2 ? io_oe[pi*DATA_WIDTH +: DATA_WIDTH] :
                                    pend_q[pi*DATA_WIDTH +: DATA_WIDTH];
  end
  // new edges are OR'd in after the W1C mask so a same-cycle set survives the clear
  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
      pend_q <= '0;
      io_out <= '0;
      io_oe <= '0;
      irq <= 1'b0;
    end else if (en) begin
      sync_q[0] <= io_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= in_q;
      pend_q <= (pend_q & ~clr) | (in_q & ~prev_q);
      io_out <= out_n;
      io_oe <= dir_n;
      irq <= |pend_q;
    end
  end
endmodule

// File: tb/tb_crash_course_cpu_gpio.sv
// tb_crash_course_cpu_gpio: table vectors, hand corner sequences and random stimulus against a history-based model
module tb_crash_course_cpu_gpio;
  localparam int SS = 2;
  logic clk = 0;
  logic sync_rst_n = 0, clk_en = 0, system_enabled = 0, reg_write_enable = 0;
  logic [31:0] io_in = 0, io_out, io_oe;
  logic [3:0] reg_addr = 0;
  logic [7:0] reg_read_data, reg_write_data = 0;
  logic irq;
  logic [23:0] io_in3 = 0, io_out3, io_oe3;
  logic [3:0] addr3 = 0;
  logic [7:0] rd3, wd3 = 0;
  logic we3 = 0, irq3;
  int vectors = 0, errors = 0;
  logic [31:0] hist[$];
  logic [31:0] m_out, m_dir, m_pend;
  logic m_irq;

  always #5 clk = ~clk;

  crash_course_cpu_gpio #(.DATA_WIDTH(8), .PORT_COUNT(4), .SYNC_STAGES(SS)) dut (
    .clk(clk), .sync_rst_n(sync_rst_n), .clk_en(clk_en), .system_enabled(system_enabled),
    .io_in(io_in), .io_out(io_out), .io_oe(io_oe), .reg_addr(reg_addr),
    .reg_read_data(reg_read_data), .reg_write_data(reg_write_data),
    .reg_write_enable(reg_write_enable), .irq(irq));

  crash_course_cpu_gpio #(.DATA_WIDTH(8), .PORT_COUNT(3), .SYNC_STAGES(SS)) u3 (
    .clk(clk), .sync_rst_n(sync_rst_n), .clk_en(clk_en), .system_enabled(system_enabled),
    .io_in(io_in3), .io_out(io_out3), .io_oe(io_oe3), .reg_addr(addr3),
    .reg_read_data(rd3), .reg_write_data(wd3), .reg_write_enable(we3), .irq(irq3));

  typedef struct {
    bit rn; bit we; logic [3:0] a; logic [7:0] wd; logic [31:0] io;
    logic [31:0] eo; logic [31:0] eoe; logic [7:0] erd; bit eirq;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // IN after n enabled samples is the sample taken SS enabled cycles earlier
  function automatic logic [31:0] in_at(int k);
    return k < 0 ? 32'h0 : hist[k];
  endfunction

  function automatic logic [7:0] model_rd(logic [3:0] a);
    logic [31:0] v;
    int p = int'(a[3:2]);
    v = a[1:0] == 2'd0 ? in_at(hist.size() - SS) : a[1:0] == 2'd1 ? m_out :
        a[1:0] == 2'd2 ? m_dir : m_pend;
    return v[p*8 +: 8];
  endfunction

  task automatic model_update();
    logic [31:0] ib, pb, clr;
    int n, p;
    if (!sync_rst_n) begin
      hist.delete();
      m_out = 0; m_dir = 0; m_pend = 0; m_irq = 0;
    end else if (clk_en && system_enabled) begin
      n = hist.size();
      ib = in_at(n - SS);
      pb = in_at(n - 1 - SS);
      clr = 0;
      p = int'(reg_addr[3:2]);
      m_irq = |m_pend;
      if (reg_write_enable) begin
        if (reg_addr[1:0] == 2'd1) m_out[p*8 +: 8] = reg_write_data;
        if (reg_addr[1:0] == 2'd2) m_dir[p*8 +: 8] = reg_write_data;
        if (reg_addr[1:0] == 2'd3) clr[p*8 +: 8] = reg_write_data;
      end
      m_pend = (m_pend & ~clr) | (ib & ~pb);
      hist.push_back(io_in);
    end
  endtask

  task automatic step(input bit rn, input bit ce, input bit se, input bit we,
                      input logic [3:0] a, input logic [7:0] wd, input logic [31:0] io);
    @(negedge clk);
    sync_rst_n = rn; clk_en = ce; system_enabled = se;
    reg_write_enable = we; reg_addr = a; reg_write_data = wd; io_in = io;
    @(posedge clk);
    model_update();
    #1;
    chk("model_io_out", io_out, m_out);
    chk("model_io_oe", io_oe, m_dir);
    chk("model_irq", irq, m_irq);
    chk("model_rd", reg_read_data, model_rd(a));
  endtask

  initial begin
    logic [31:0] io;
    tbl[0]  = '{rn:0, we:1, a:4'h9, wd:8'hFF, io:32'h0,  eo:32'h0,        eoe:32'h0,        erd:8'h00, eirq:0};
    tbl[1]  = '{rn:1, we:1, a:4'h9, wd:8'hA5, io:32'h0,  eo:32'h00A50000, eoe:32'h0,        erd:8'hA5, eirq:0};
    tbl[2]  = '{rn:1, we:1, a:4'hA, wd:8'h0F, io:32'h0,  eo:32'h00A50000, eoe:32'h000F0000, erd:8'h0F, eirq:0};
    tbl[3]  = '{rn:1, we:0, a:4'h9, wd:8'h00, io:32'h0,  eo:32'h00A50000, eoe:32'h000F0000, erd:8'hA5, eirq:0};
    tbl[4]  = '{rn:1, we:0, a:4'h0, wd:8'h00, io:32'h0,  eo:32'h00A50000, eoe:32'h000F0000, erd:8'h00, eirq:0};
    tbl[5]  = '{rn:1, we:0, a:4'h0, wd:8'h00, io:32'h81, eo:32'h00A50000, eoe:32'h000F0000, erd:8'h00, eirq:0};
    tbl[6]  = '{rn:1, we:0, a:4'h0, wd:8'h00, io:32'h81, eo:32'h00A50000, eoe:32'h000F0000, erd:8'h81, eirq:0};
    tbl[7]  = '{rn:1, we:0, a:4'h3, wd:8'h00, io:32'h81, eo:32'h00A50000, eoe:32'h000F0000, erd:8'h81, eirq:0};
    tbl[8]  = '{rn:1, we:0, a:4'h3, wd:8'h00, io:32'h81, eo:32'h00A50000, eoe:32'h000F0000, erd:8'h81, eirq:1};
    tbl[9]  = '{rn:1, we:1, a:4'h3, wd:8'h81, io:32'h81, eo:32'h00A50000, eoe:32'h000F0000, erd:8'h00, eirq:1};
    tbl[10] = '{rn:1, we:0, a:4'h3, wd:8'h00, io:32'h81, eo:32'h00A50000, eoe:32'h000F0000, erd:8'h00, eirq:0};
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].rn, i != 0, 1, tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].io);
      chk($sformatf("tbl%0d_io_out", i), io_out, tbl[i].eo);
      chk($sformatf("tbl%0d_io_oe", i), io_oe, tbl[i].eoe);
      chk($sformatf("tbl%0d_rd", i), reg_read_data, {24'h0, tbl[i].erd});
      chk($sformatf("tbl%0d_irq", i), irq, tbl[i].eirq);
    end
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 4'h7, 8'h00, 32'h0300);
    chk("w1c_pend_init", reg_read_data, 8'h03);
    for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 4'h7, 8'h00, 32'h0200);
    for (int i = 0; i < 2; i++) step(1, 1, 1, 0, 4'h7, 8'h00, 32'h0300);
    step(1, 1, 1, 1, 4'h7, 8'h01, 32'h0300);
    chk("w1c_set_wins", reg_read_data, 8'h03);
    step(1, 1, 1, 1, 4'h7, 8'h01, 32'h0300);
    chk("w1c_clear_bit0", reg_read_data, 8'h02);
    step(1, 1, 1, 1, 4'h7, 8'h02, 32'h0300);
    chk("w1c_clear_bit1", reg_read_data, 8'h00);
    chk("w1c_irq_held", irq, 1'b1);
    step(1, 1, 1, 0, 4'h7, 8'h00, 32'h0300);
    chk("w1c_irq_fall", irq, 1'b0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 1, 4'h1, 8'h55, i[0] ? 32'hFFFFFFFF : 32'h0);
    chk("gate_out_hold", io_out[7:0], 8'h00);
    chk("gate_rd_hold", reg_read_data, 8'h00);
    chk("gate_irq_hold", irq, 1'b0);
    step(1, 1, 1, 1, 4'h1, 8'h55, 32'h0);
    chk("gate_resume_out", io_out[7:0], 8'h55);
    step(0, 1, 1, 0, 4'h0, 8'h00, 32'h0);
    io_in3 = 24'hFFFFFF; we3 = 1; addr3 = 4'hD; wd3 = 8'hFF;
    step(1, 1, 1, 0, 4'h0, 8'h00, 32'h0);
    chk("oor_out", io_out3, 24'h0);
    addr3 = 4'hE;
    step(1, 1, 1, 0, 4'h0, 8'h00, 32'h0);
    chk("oor_oe", io_oe3, 24'h0);
    addr3 = 4'h1; wd3 = 8'h3C;
    step(1, 1, 1, 0, 4'h0, 8'h00, 32'h0);
    chk("inrange_out", io_out3, 24'h00003C);
    we3 = 0; addr3 = 4'h0;
    step(1, 1, 1, 0, 4'h0, 8'h00, 32'h0);
    chk("inrange_in", rd3, 8'hFF);
    addr3 = 4'hC; #1;
    chk("oor_rd_in", rd3, 8'h00);
    addr3 = 4'hD; #1;
    chk("oor_rd_out", rd3, 8'h00);
    io = 0;
    for (int i = 0; i < 400; i++) begin
      if (i % 4 == 0) io = $urandom;
      step(($urandom % 40) != 0, ($urandom % 6) != 0, ($urandom % 6) != 0, 1'($urandom),
           4'($urandom), 8'($urandom), io);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
